// File: rtl/st_rmw_unit.sv
// -----------------------------------------------------------------------------
// st_rmw_unit
//
// Store-side narrowing unit. Takes a 32-bit register value plus a byte address
// and a size (byte / half / word) and writes it into a data memory that only
// supports whole-word writes. Byte and half stores are done as read-modify-
// write: the containing word is read, the target lane(s) are replaced, and the
// merged word is written back. Word stores are written directly.
//
// The core hands over one request at a time and then waits for the one-cycle
// done (store committed) or err (misaligned / reserved size rejected) pulse.
//
// Optional feature (macro RMW_BYPASS_EN):
//   When defined, the memory is assumed to have byte enables. A mem_be port is
//   added, every aligned store is written in a single cycle with the data
//   replicated across lanes, and no read is ever issued.
//
// Parameters:
//   ADDR_W     word-address width of the data memory
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   req_valid  store request valid
//   req_ready  unit idle and able to accept a request
//   req_addr   byte address of the store
//   req_data   register source data, narrow stores use the low bits
//   req_size   00 byte, 01 half, 10 word, 11 reserved (rejected)
//   mem_addr   word address to data memory (holds when strobes are low)
//   mem_rd_en  read strobe, mem_rdata is valid one cycle later
//   mem_rdata  memory read data
//   mem_wr_en  one-cycle write strobe
//   mem_wdata  full word to write (holds when strobes are low)
//   mem_be     byte enables, only with RMW_BYPASS_EN, zero unless writing
//   done       one-cycle pulse, store committed
//   err        one-cycle pulse, store rejected
// -----------------------------------------------------------------------------
module st_rmw_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
`ifdef RMW_BYPASS_EN
  output logic [3:0]        mem_be,
`endif
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_RD,
    S_MRG,
    S_WR
  } state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic                w_accept;
  logic                w_misaligned;
  logic                w_direct;
  logic [31:0]         w_acceptWdata;
  logic [31:0]         w_merged;

  // Captured request fields; only the low half of the data is ever needed
  // after accept because word data goes straight into r_memWdata.
  logic [1:0]          r_lane;
  logic [1:0]          r_size;
  logic [15:0]         r_data;

  logic [ADDR_W-1:0]   r_memAddr;
  logic [31:0]         r_memWdata;

  // Address bits above the memory range are deliberately dropped so the
  // address wraps inside the memory.
  logic                w_unusedAddr;
  assign w_unusedAddr = ^req_addr[31:ADDR_W+2];

`ifdef RMW_BYPASS_EN
  logic [3:0]          r_be;
  logic [3:0]          w_acceptBe;
`endif

  assign w_accept = req_valid & req_ready;

  // Alignment rules: halves need an even address, words a multiple of four,
  // and the reserved size is always rejected.
  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b1;
    endcase
  end

`ifdef RMW_BYPASS_EN
  // With byte enables every aligned store is a single write; the data is
  // replicated so the enabled lanes see the right bytes whatever the offset.
  assign w_direct = 1'b1;

  always_comb begin
    w_acceptWdata = req_data;
    w_acceptBe    = 4'b1111;
    case (req_size)
      2'b00: begin
        w_acceptWdata = {4{req_data[7:0]}};
        w_acceptBe    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        w_acceptWdata = {2{req_data[15:0]}};
        w_acceptBe    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_acceptWdata = req_data;
        w_acceptBe    = 4'b1111;
      end
    endcase
  end
`else
  // Without byte enables only full words can skip the read.
  assign w_direct      = (req_size == 2'b10);
  assign w_acceptWdata = req_data;
`endif

  // Little-endian lane merge of the captured store data into the word that
  // was read back; bits outside the target lane(s) pass through untouched.
  always_comb begin
    w_merged = mem_rdata;
    case (r_size)
      2'b00: w_merged[{r_lane, 3'b000} +: 8] = r_data[7:0];
      2'b01: begin
        if (r_lane[1]) begin
          w_merged[31:16] = r_data;
        end else begin
          w_merged[15:0] = r_data;
        end
      end
      default: w_merged = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Rejections take priority over any write path.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misaligned) begin
            w_nextState = S_ERR;
          end else if (w_direct) begin
            w_nextState = S_WR;
          end else begin
            w_nextState = S_RD;
          end
        end
      end
      S_ERR:   w_nextState = S_IDLE;
      S_RD:    w_nextState = S_MRG;
      S_MRG:   w_nextState = S_WR;
      S_WR:    w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Output logic. Strobes and pulses are pure decodes of the state, so read
  // and write can never overlap; address and data come from holding registers.
  always_comb begin
    req_ready = (r_state == S_IDLE) && !rst;
    mem_rd_en = (r_state == S_RD);
    mem_wr_en = (r_state == S_WR);
    done      = (r_state == S_WR);
    err       = (r_state == S_ERR);
    mem_addr  = r_memAddr;
    mem_wdata = r_memWdata;
`ifdef RMW_BYPASS_EN
    mem_be    = (r_state == S_WR) ? r_be : 4'b0000;
`endif
  end

  // Request capture and memory-facing holding registers. The memory address
  // and data only move on an accepted, aligned request or on the merge, so a
  // rejected store leaves the memory bus exactly as it was.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane     <= 2'b00;
      r_size     <= 2'b00;
      r_data     <= 16'h0000;
      r_memAddr  <= '0;
      r_memWdata <= 32'h0000_0000;
    end else begin
      if (w_accept) begin
        r_lane <= req_addr[1:0];
        r_size <= req_size;
        r_data <= req_data[15:0];
        if (!w_misaligned) begin
          r_memAddr <= req_addr[ADDR_W+1:2];
          if (w_direct) begin
            r_memWdata <= w_acceptWdata;
          end
        end
      end else if (r_state == S_MRG) begin
        r_memWdata <= w_merged;
      end
    end
  end

`ifdef RMW_BYPASS_EN
  // Byte-enable register, presented on mem_be only during the write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_be <= 4'b0000;
    end else if (w_accept && !w_misaligned) begin
      r_be <= w_acceptBe;
    end
  end
`endif

endmodule

// File: tb/tb_st_rmw_unit.sv
// -----------------------------------------------------------------------------
// tb_st_rmw_unit
//
// Self-checking bench for st_rmw_unit. A small word memory answers the unit's
// read and write strobes; expected behaviour comes from a byte-level model of
// the store rules and a reference copy of memory kept by the bench. Builds
// with or without RMW_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_st_rmw_unit;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              err;
`ifdef RMW_BYPASS_EN
  logic [3:0]        mem_be;
`endif

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  st_rmw_unit #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
`ifdef RMW_BYPASS_EN
    .mem_be    (mem_be),
`endif
    .done      (done),
    .err       (err)
  );

  // Memory the unit talks to, plus the bench's own reference copy.
  logic [31:0] memArr [0:1023];
  logic [31:0] refMem [0:1023];
  logic        pokeEn = 1'b0;
  logic [9:0]  pokeIdx = '0;
  logic [31:0] pokeVal = '0;
  logic [31:0] beWord;

  // Read data is only meaningful the cycle after a read strobe; otherwise
  // it carries noise so a mistimed capture shows up.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= memArr[mem_addr];
    else           mem_rdata <= $urandom;
    if (pokeEn) begin
      memArr[pokeIdx] <= pokeVal;
    end else if (mem_wr_en) begin
`ifdef RMW_BYPASS_EN
      beWord = memArr[mem_addr];
      for (int i = 0; i < 4; i++) if (mem_be[i]) beWord[8*i +: 8] = mem_wdata[8*i +: 8];
      memArr[mem_addr] <= beWord;
`else
      memArr[mem_addr] <= mem_wdata;
`endif
    end
  end

  // Per-cycle observations of one store; index c is cycle T+c.
  // obsVec bit order: {mem_rd_en, mem_wr_en, done, err, req_ready}.
  logic [4:0]        obsVec   [1:4];
  logic [ADDR_W-1:0] obsAddr  [1:4];
  logic [31:0]       obsWdata [1:4];
  logic [3:0]        obsBe    [1:4];
  logic [ADDR_W-1:0] prevAddr;
  logic [31:0]       prevWdata;
  logic              stimTimeout;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pokeWord(input logic [9:0] idx, input logic [31:0] val);
    pokeEn  = 1'b1;
    pokeIdx = idx;
    pokeVal = val;
    refMem[idx] = val;
    @(posedge clk); #1;
    pokeEn = 1'b0;
  endtask

  // Present one store at cycle T and record the four following cycles.
  // Request fields are scrambled after accept so any re-sampling is visible.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int guard;
    guard = 0;
    stimTimeout = 1'b0;
    while (req_ready !== 1'b1 && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    if (req_ready !== 1'b1) begin
      stimTimeout = 1'b1;
      return;
    end
    prevAddr  = mem_addr;
    prevWdata = mem_wdata;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_data  = $urandom;
      req_size  = 2'($urandom);
      obsVec[c]   = {mem_rd_en, mem_wr_en, done, err, req_ready};
      obsAddr[c]  = mem_addr;
      obsWdata[c] = mem_wdata;
`ifdef RMW_BYPASS_EN
      obsBe[c] = mem_be;
`else
      obsBe[c] = 4'b0000;
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    testCount++;
    if ({mem_rd_en, mem_wr_en, done, err, req_ready} !== 5'b00000) begin
      failCount++;
      $display("[TB] FAIL reset_strobes: got %b required 00000", {mem_rd_en, mem_wr_en, done, err, req_ready});
    end
    testCount++;
    if ({mem_addr, mem_wdata} !== {{ADDR_W{1'b0}}, 32'h0}) begin
      failCount++;
      $display("[TB] FAIL reset_bus: got addr %h wdata %h required 0/0", mem_addr, mem_wdata);
    end
`ifdef RMW_BYPASS_EN
    testCount++;
    if (mem_be !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL reset_be: got %b required 0000", mem_be);
    end
`endif
    rst = 1'b0;
    #1;
    testCount++;
    if (req_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_ready_after: got %b required 1", req_ready);
    end
  endtask

  task automatic test_directed();
    // Byte store into lane 1 of word 0x10.
    pokeWord(10'h010, 32'h11223344);
    applyStimulus(32'h0000_0041, 32'h0000_00AB, 2'b00);
`ifdef RMW_BYPASS_EN
    testCount++;
    if ({obsVec[1], obsAddr[1], obsWdata[1], obsBe[1]} !== {5'b01100, 10'h010, 32'hABABABAB, 4'b0010}) begin
      failCount++;
      $display("[TB] FAIL byte_bypass: got %b %h %h %b required 01100 010 ababab 0010", obsVec[1], obsAddr[1], obsWdata[1], obsBe[1]);
    end
`else
    testCount++;
    if ({obsVec[1], obsAddr[1]} !== {5'b10000, 10'h010}) begin
      failCount++;
      $display("[TB] FAIL byte_read: got %b addr %h required 10000 addr 010", obsVec[1], obsAddr[1]);
    end
    testCount++;
    if ({obsVec[2], obsVec[3], obsVec[4]} !== {5'b00000, 5'b01100, 5'b00001}) begin
      failCount++;
      $display("[TB] FAIL byte_timeline: got %b %b %b required 00000 01100 00001", obsVec[2], obsVec[3], obsVec[4]);
    end
    testCount++;
    if ({obsAddr[3], obsWdata[3]} !== {10'h010, 32'h1122AB44}) begin
      failCount++;
      $display("[TB] FAIL byte_write: got addr %h data %h required 010 1122ab44", obsAddr[3], obsWdata[3]);
    end
`endif

    // Half store into the upper half of the same original word.
    pokeWord(10'h010, 32'h11223344);
    applyStimulus(32'h0000_0042, 32'hFFFF_BEEF, 2'b01);
`ifdef RMW_BYPASS_EN
    testCount++;
    if ({obsVec[1], obsWdata[1], obsBe[1]} !== {5'b01100, 32'hBEEFBEEF, 4'b1100}) begin
      failCount++;
      $display("[TB] FAIL half_bypass: got %b %h %b required 01100 beefbeef 1100", obsVec[1], obsWdata[1], obsBe[1]);
    end
`else
    testCount++;
    if ({obsVec[1], obsVec[2], obsVec[3], obsVec[4]} !== {5'b10000, 5'b00000, 5'b01100, 5'b00001}) begin
      failCount++;
      $display("[TB] FAIL half_timeline: got %b %b %b %b required 10000 00000 01100 00001", obsVec[1], obsVec[2], obsVec[3], obsVec[4]);
    end
    testCount++;
    if (obsWdata[3] !== 32'hBEEF3344) begin
      failCount++;
      $display("[TB] FAIL half_write: got %h required beef3344", obsWdata[3]);
    end
`endif

    // Word store, then the same store with high address bits set (wraps).
    applyStimulus(32'h0000_0040, 32'hDEAD_BEEF, 2'b10);
    testCount++;
    if ({obsVec[1], obsAddr[1], obsWdata[1], obsVec[2]} !== {5'b01100, 10'h010, 32'hDEADBEEF, 5'b00001}) begin
      failCount++;
      $display("[TB] FAIL word_write: got %b %h %h %b required 01100 010 deadbeef 00001", obsVec[1], obsAddr[1], obsWdata[1], obsVec[2]);
    end
    applyStimulus(32'hFFFF_F040, 32'h1234_5678, 2'b10);
    testCount++;
    if ({obsVec[1], obsAddr[1], obsWdata[1]} !== {5'b01100, 10'h010, 32'h12345678}) begin
      failCount++;
      $display("[TB] FAIL word_wrap: got %b %h %h required 01100 010 12345678", obsVec[1], obsAddr[1], obsWdata[1]);
    end
  endtask

  task automatic test_error();
    logic [31:0] addrs [2];
    logic [1:0]  sizes [2];
    addrs[0] = 32'h0000_0043; sizes[0] = 2'b01;
    addrs[1] = 32'h0000_0040; sizes[1] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(addrs[k], 32'h5555_AAAA, sizes[k]);
      testCount++;
      if ({obsVec[1], obsVec[2], obsVec[3], obsVec[4]} !== {5'b00010, 5'b00001, 5'b00001, 5'b00001}) begin
        failCount++;
        $display("[TB] FAIL err_timeline%0d: got %b %b %b %b required 00010 00001 00001 00001", k, obsVec[1], obsVec[2], obsVec[3], obsVec[4]);
      end
      testCount++;
      if ({obsAddr[1], obsWdata[1], obsAddr[4], obsWdata[4]} !== {prevAddr, prevWdata, prevAddr, prevWdata}) begin
        failCount++;
        $display("[TB] FAIL err_hold%0d: got %h %h required %h %h", k, obsAddr[4], obsWdata[4], prevAddr, prevWdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   kRst;
    logic wrSeen;
    logic doneSeen;
`ifdef RMW_BYPASS_EN
    kRst = 0;
`else
    kRst = 2;
`endif
    wrSeen   = 1'b0;
    doneSeen = 1'b0;
    pokeWord(10'h005, 32'hCAFEF00D);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0015;
    req_data  = 32'h0000_0077;
    req_size  = 2'b00;
    rst       = (kRst == 0);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = (c == kRst);
      #1;
      if (mem_wr_en !== 1'b0) wrSeen = 1'b1;
      if (done !== 1'b0) doneSeen = 1'b1;
      if (c == kRst + 1) begin
        testCount++;
        if ({mem_rd_en, mem_wr_en, done, err, req_ready, mem_addr, mem_wdata} !== {5'b00001, {ADDR_W{1'b0}}, 32'h0}) begin
          failCount++;
          $display("[TB] FAIL rstmid_outputs: got %b addr %h wdata %h required 00001 0 0", {mem_rd_en, mem_wr_en, done, err, req_ready}, mem_addr, mem_wdata);
        end
      end
    end
    rst = 1'b0;
    testCount++;
    if ({wrSeen, doneSeen} !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL rstmid_dropped: got wr/done seen %b required 00", {wrSeen, doneSeen});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] doneBits;
    logic [5:0] wrBits;
    logic [5:0] rdBits;
    doneBits = '0;
    wrBits   = '0;
    rdBits   = '0;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0044;
    req_data  = 32'h0BAD_CAFE;
    req_size  = 2'b10;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      doneBits = {doneBits[4:0], done};
      wrBits   = {wrBits[4:0], mem_wr_en};
      rdBits   = {rdBits[4:0], mem_rd_en};
    end
    req_valid = 1'b0;
    refMem[10'h011] = 32'h0BAD_CAFE;
    testCount++;
    if ({doneBits, wrBits, rdBits} !== {6'b101010, 6'b101010, 6'b000000}) begin
      failCount++;
      $display("[TB] FAIL back_to_back: got done %b wr %b rd %b required 101010 101010 000000", doneBits, wrBits, rdBits);
    end
  endtask

  task automatic test_random();
    logic [31:0] rnd, a, d, oldWord, newWord, repl, expWd;
    logic [1:0]  s;
    logic [9:0]  idx;
    logic [3:0]  be;
    logic [7:0]  b [4];
    logic [4:0]  e [1:4];
    logic        mis, direct;
    int          lane, nb, wc;
    for (int i = 0; i <= 16; i++) pokeWord(10'(i), $urandom);
    for (int n = 0; n < 80; n++) begin
      rnd  = $urandom;
      a    = {rnd[31:12], 6'b000000, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      d    = $urandom;
      s    = 2'($urandom_range(0, 3));
      idx  = a[11:2];
      lane = int'(a[1:0]);
      nb   = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
      mis  = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
`ifdef RMW_BYPASS_EN
      direct = 1'b1;
`else
      direct = (s == 2'b10);
`endif
      // Byte-level model of the store.
      oldWord = refMem[idx];
      for (int i = 0; i < 4; i++) b[i] = oldWord[8*i +: 8];
      be = 4'b0000;
      if (!mis) begin
        for (int i = 0; i < nb; i++) begin
          b[lane + i]  = d[8*i +: 8];
          be[lane + i] = 1'b1;
        end
      end
      newWord = {b[3], b[2], b[1], b[0]};
      for (int i = 0; i < 4; i++) repl[8*i +: 8] = d[8*(i % nb) +: 8];
`ifdef RMW_BYPASS_EN
      expWd = repl;
`else
      expWd = newWord;
`endif
      if (mis) begin
        e[1] = 5'b00010; e[2] = 5'b00001; e[3] = 5'b00001; e[4] = 5'b00001; wc = 0;
      end else if (direct) begin
        e[1] = 5'b01100; e[2] = 5'b00001; e[3] = 5'b00001; e[4] = 5'b00001; wc = 1;
      end else begin
        e[1] = 5'b10000; e[2] = 5'b00000; e[3] = 5'b01100; e[4] = 5'b00001; wc = 3;
      end

      applyStimulus(a, d, s);
      testCount++;
      if (stimTimeout !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL rnd%0d_ready_timeout: got timeout required ready", n);
      end
      for (int c = 1; c <= 4; c++) begin
        testCount++;
        if (obsVec[c] !== e[c]) begin
          failCount++;
          $display("[TB] FAIL rnd%0d_cycle%0d: got %b required %b (addr %h size %b)", n, c, obsVec[c], e[c], a, s);
        end
      end
      if (mis) begin
        testCount++;
        if ({obsAddr[1], obsWdata[1], obsAddr[4], obsWdata[4]} !== {prevAddr, prevWdata, prevAddr, prevWdata}) begin
          failCount++;
          $display("[TB] FAIL rnd%0d_err_hold: got %h %h required %h %h", n, obsAddr[4], obsWdata[4], prevAddr, prevWdata);
        end
      end else begin
        testCount++;
        if ({obsAddr[wc], obsWdata[wc]} !== {idx, expWd}) begin
          failCount++;
          $display("[TB] FAIL rnd%0d_write: got addr %h data %h required %h %h", n, obsAddr[wc], obsWdata[wc], idx, expWd);
        end
        testCount++;
        if ({obsAddr[4], obsWdata[4]} !== {idx, expWd}) begin
          failCount++;
          $display("[TB] FAIL rnd%0d_hold: got addr %h data %h required %h %h", n, obsAddr[4], obsWdata[4], idx, expWd);
        end
        if (!direct) begin
          testCount++;
          if ({obsAddr[1], obsAddr[2], obsWdata[2]} !== {idx, idx, prevWdata}) begin
            failCount++;
            $display("[TB] FAIL rnd%0d_read: got addr %h/%h data %h required %h %h", n, obsAddr[1], obsAddr[2], obsWdata[2], idx, prevWdata);
          end
        end
`ifdef RMW_BYPASS_EN
        testCount++;
        if ({obsBe[1], obsBe[2]} !== {be, 4'b0000}) begin
          failCount++;
          $display("[TB] FAIL rnd%0d_be: got %b %b required %b 0000", n, obsBe[1], obsBe[2], be);
        end
`endif
        refMem[idx] = newWord;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = '0;
    test_reset();
    test_directed();
    test_error();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
